// File: rtl/mult_div_ctrl_if.sv
// Control/status bundle between the main control FSM and the mult/div sequencer.
interface mult_div_ctrl_if #(parameter int CNT_W = 6);
  logic             start_mult;
  logic             start_div;
  logic             divisor_zero;
  logic             mult_rem_zero;
  logic             busy;
  logic             load_ops;
  logic             mult_step;
  logic             div_step;
  logic             hi_we;
  logic             lo_we;
  logic             hilo_src;
  logic             done;
  logic             div_zero_exc;
  logic [CNT_W-1:0] step_count;

  modport master (
    output start_mult, start_div, divisor_zero, mult_rem_zero,
    input  busy, load_ops, mult_step, div_step, hi_we, lo_we, hilo_src,
           done, div_zero_exc, step_count
  );

  modport slave (
    input  start_mult, start_div, divisor_zero, mult_rem_zero,
    output busy, load_ops, mult_step, div_step, hi_we, lo_we, hilo_src,
           done, div_zero_exc, step_count
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Sequencer for the iterative MULT/DIV datapath: load, step N times, write HI/LO, pulse done.
// Optional MULT_EARLY_TERM_EN: end a multiply early once the remaining multiplier bits are zero.
module mult_div_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MULT_RUN, S_DIV_RUN, S_WB, S_DONE, S_DZ
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, nxt;
  logic             op_div, op_div_nxt;
  logic [CNT_W-1:0] cnt;
  logic             hilo_q;

`ifndef MULT_EARLY_TERM_EN
  logic unused_rem_zero;
  assign unused_rem_zero = bus.mult_rem_zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_div <= 1'b0;
      cnt    <= '0;
      hilo_q <= 1'b0;
    end else begin
      state  <= nxt;
      op_div <= op_div_nxt;
      case (state)
        S_LOAD:     cnt <= '0;
        S_MULT_RUN: if (cnt != MULT_LAST) cnt <= cnt + 1'b1;
        S_DIV_RUN:  if (cnt != DIV_LAST)  cnt <= cnt + 1'b1;
        default:    cnt <= cnt;
      endcase
      // hilo_src is only updated on entry to WB so it holds between operations
      if (nxt == S_WB) hilo_q <= op_div;
    end
  end

  always_comb begin
    nxt        = state;
    op_div_nxt = op_div;
    case (state)
      S_IDLE: begin
        if (bus.start_mult) begin
          nxt        = S_LOAD;
          op_div_nxt = 1'b0;
        end else if (bus.start_div) begin
          nxt        = S_LOAD;
          op_div_nxt = 1'b1;
        end
      end
      S_LOAD:     nxt = op_div ? (bus.divisor_zero ? S_DZ : S_DIV_RUN) : S_MULT_RUN;
      S_MULT_RUN: begin
        if (cnt == MULT_LAST) nxt = S_WB;
`ifdef MULT_EARLY_TERM_EN
        else if (bus.mult_rem_zero && cnt != '0) nxt = S_WB;
`endif
      end
      S_DIV_RUN:  if (cnt == DIV_LAST) nxt = S_WB;
      S_WB:       nxt = S_DONE;
      S_DONE:     nxt = S_IDLE;
      S_DZ:       nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  assign bus.busy         = (state == S_LOAD) || (state == S_MULT_RUN) || (state == S_DIV_RUN) ||
                            (state == S_WB)   || (state == S_DZ);
  assign bus.load_ops     = (state == S_LOAD);
  assign bus.mult_step    = (state == S_MULT_RUN);
  assign bus.div_step     = (state == S_DIV_RUN);
  assign bus.hi_we        = (state == S_WB);
  assign bus.lo_we        = (state == S_WB);
  assign bus.done         = (state == S_DONE);
  assign bus.div_zero_exc = (state == S_DZ);
  assign bus.hilo_src     = hilo_q;
  assign bus.step_count   = cnt;
endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Sequencer for the iterative multiply/divide unit that serves MULT and DIV.
- Accepts a one-cycle start request from the main control FSM, loads operands and steps the datapath a counted number of iterations.
- Writes the result to HI/LO, then returns a done pulse.
- Flags divide-by-zero without touching HI/LO, so the control FSM can branch to its exception path.

Parameters:
- MULT_CYCLES, 32, number of multiplier iteration cycles (1..63).
- DIV_CYCLES, 32, number of divider iteration cycles (1..63).
- CNT_W, 6, width of iteration counter; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_mult  in  1  request a multiply; sampled only in IDLE.
- start_div  in  1  request a divide; sampled only in IDLE.
- divisor_zero  in  1  datapath flag: divisor operand == 0; valid during LOAD.
- mult_rem_zero  in  1  datapath flag: remaining multiplier bits all zero; used only with the optional feature.
- busy  out  1  high from LOAD through WB/DZ.
- load_ops  out  1  load operand registers and clear accumulators.
- mult_step  out  1  advance multiplier one iteration.
- div_step  out  1  advance divider one iteration.
- hi_we  out  1  HI write enable.
- lo_we  out  1  LO write enable.
- hilo_src  out  1  0 = HI/LO from multiplier, 1 = from divider.
- done  out  1  one-cycle completion pulse.
- div_zero_exc  out  1  one-cycle divide-by-zero pulse.
- step_count  out  CNT_W  current iteration index.

Behaviour:
- One clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values: state IDLE, step_count 0, op latch 0; all outputs 0.
- Outputs are Moore, decoded from the state register. step_count is a direct register output.
- States and transitions:
  - IDLE: start_mult -> LOAD with op=MULT; else start_div -> LOAD with op=DIV. Both high at once: MULT wins, start_div dropped.
  - LOAD: load_ops=1, busy=1, step_count<=0.
    - op=DIV and divisor_zero=1 -> DZ.
    - op=DIV otherwise -> DIV_RUN.
    - op=MULT -> MULT_RUN.
  - MULT_RUN: mult_step=1, busy=1, step_count increments each cycle. When step_count==MULT_CYCLES-1 -> WB.
  - DIV_RUN: div_step=1, busy=1, same counting. When step_count==DIV_CYCLES-1 -> WB.
  - WB: hi_we=lo_we=1, hilo_src=op, busy=1 -> DONE.
  - DONE: done=1, busy=0 -> IDLE.
  - DZ: div_zero_exc=1, busy=1, no HI/LO write, done stays 0 -> IDLE.
- Latency, with start sampled at edge T:
  - LOAD occupies cycle T+1.
  - Run occupies N cycles.
  - WB is at T+N+2.
  - done is high in cycle T+N+3.
  - Defaults: MULT or DIV with N=32 gives done at T+35.
  - Divide-by-zero: div_zero_exc high in cycle T+2.
- Start requests outside IDLE, including during DONE, are ignored; no queuing.
- The requester must hold operands stable through LOAD. Behaviour is undefined for stale operands.
- step_count never wraps: it is cleared in LOAD and saturates at its terminal value.
- Reset mid-operation returns to IDLE on the next edge. No hi_we/lo_we, done or div_zero_exc pulse is produced.
- Unreachable state encodings recover to IDLE.
- hilo_src holds its last value outside WB. It is only meaningful while hi_we/lo_we are high.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in MULT_RUN, mult_rem_zero=1 with step_count>=1 sends the next state to WB. The current cycle's mult_step still occurs. Latency shrinks accordingly; DIV_RUN is unaffected.
- Not defined: mult_rem_zero is ignored and MULT always runs exactly MULT_CYCLES iterations.

Test Plan:
- Reset, then start_mult pulse at T, defaults, feature off -> load_ops at T+1; mult_step high T+2..T+33; hi_we=lo_we=1, hilo_src=0 at T+34; done at T+35; busy low again at T+35.
- start_div at T, divisor_zero=0 -> div_step high 32 cycles; WB with hilo_src=1 at T+34; done at T+35.
- start_div at T, divisor_zero=1 in LOAD -> div_zero_exc at T+2 only; hi_we, lo_we and done stay 0; back in IDLE at T+3.
- start_mult and start_div high together, then start_div re-pulsed at T+10 -> only the multiply runs (hilo_src=0 at WB); the T+10 pulse is ignored.
- reset asserted at T+15 during MULT_RUN -> IDLE at T+16; all outputs 0; no HI/LO write or done for the remainder.
- MULT_EARLY_TERM_EN defined, mult_rem_zero raised when step_count=3 -> WB next cycle (T+6), done at T+7. Same stimulus with the macro undefined -> done at T+35.
